// File: rtl/da2_multi_pkg.sv
// rtl/da2_multi_pkg.sv - shared frame constants, power-down codes and FSM states for da2_multi
package da2_multi_pkg;

  localparam int FRAME_W = 16;
  localparam int FIELD_W = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] pd,
                                                     input logic [FIELD_W-1:0] sample);
    return {2'b00, pd, sample};
  endfunction

endpackage

// File: rtl/da2_multi_sclk_gen.sv
// rtl/da2_multi_sclk_gen.sv - SCLK half-period generator with rise/fall strobes
// Strobes are high in the cycle before the edge that changes the SCLK level.
module da2_multi_sclk_gen #(
  parameter int SCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCLK_HALF - 1);

  logic [CW-1:0] cnt;
  logic          toggle;

  assign toggle = en && (cnt == LAST);
  assign rise   = toggle && !sclk;
  assign fall   = toggle && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (toggle) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/da2_multi.sv
// rtl/da2_multi.sv - multi-channel Pmod DA2 (DAC121S101) driver; DA2_DBUF_EN adds a pending-update buffer
module da2_multi
  import da2_multi_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 12,
  parameter int SCLK_HALF = 2,
  parameter int SYNC_GAP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     SCLK,
  output logic                     SYNC,
  output logic [NUM_CH-1:0]        SDATA,
  input  logic [NUM_CH*DATA_W-1:0] value,
  input  logic [NUM_CH*2-1:0]      mode,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     update,
  output logic                     busy,
  output logic                     done
);

  localparam int PAD = FIELD_W - DATA_W;
  localparam int GW  = $clog2(SYNC_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

  state_t              state, state_next;
  logic                load, shift_end, gap_end;
  logic                sclk_rise, sclk_fall;
  logic [4:0]          bit_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [DATA_W-1:0]   hold_val  [NUM_CH];
  logic [1:0]          hold_mode [NUM_CH];
  logic [DATA_W-1:0]   ld_val    [NUM_CH];
  logic [1:0]          ld_mode   [NUM_CH];
  logic [FRAME_W-1:0]  shift_reg [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] src_value;
  logic [NUM_CH*2-1:0]      src_mode;
  logic [NUM_CH-1:0]        src_en;

  da2_multi_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .sclk (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

`ifdef DA2_DBUF_EN
  logic                     pend, use_pend;
  logic [NUM_CH*DATA_W-1:0] pend_value;
  logic [NUM_CH*2-1:0]      pend_mode;
  logic [NUM_CH-1:0]        pend_en;

  assign src_value = use_pend ? pend_value : value;
  assign src_mode  = use_pend ? pend_mode  : mode;
  assign src_en    = use_pend ? pend_en    : ch_en;
`else
  assign src_value = value;
  assign src_mode  = mode;
  assign src_en    = ch_en;
`endif

  assign shift_end = (state == SHIFT) && sclk_rise && (bit_cnt == 5'd16);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ld_val[i]   = src_en[i] ? src_value[i*DATA_W +: DATA_W] : hold_val[i];
      ld_mode[i]  = src_en[i] ? src_mode[i*2 +: 2] : hold_mode[i];
      SDATA[i]    = shift_reg[i][FRAME_W-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
`ifdef DA2_DBUF_EN
    use_pend   = 1'b0;
`endif
    case (state)
      IDLE: if (update && !busy) begin
        load       = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: if (shift_end) state_next = GAP;
      GAP: if (gap_end) begin
        state_next = IDLE;
`ifdef DA2_DBUF_EN
        if (pend) begin
          load       = 1'b1;
          use_pend   = 1'b1;
          state_next = SHIFT;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SYNC    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_val[i]  <= '0;
        hold_mode[i] <= PD_NORMAL;
        shift_reg[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (load) begin
        SYNC    <= 1'b0;
        busy    <= 1'b1;
        bit_cnt <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          hold_val[i]  <= ld_val[i];
          hold_mode[i] <= ld_mode[i];
          shift_reg[i] <= make_frame(ld_mode[i], 12'(ld_val[i]) << PAD);
        end
      end
      case (state)
        SHIFT: begin
          if (sclk_fall) bit_cnt <= bit_cnt + 5'd1;
          if (shift_end) begin
            SYNC    <= 1'b1;
            gap_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) shift_reg[i] <= '0;
          end else if (sclk_rise) begin
            for (int i = 0; i < NUM_CH; i++)
              shift_reg[i] <= {shift_reg[i][FRAME_W-2:0], 1'b0};
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_end) begin
            done <= 1'b1;
            if (!load) busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DA2_DBUF_EN
  // A capture on the same edge the buffered frame launches wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= 1'b0;
      pend_value <= '0;
      pend_mode  <= '0;
      pend_en    <= '0;
    end else if (update && busy) begin
      pend       <= 1'b1;
      pend_value <= value;
      pend_mode  <= mode;
      pend_en    <= ch_en;
    end else if (use_pend) begin
      pend <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_da2_multi.sv
// tb/tb_da2_multi.sv - scoreboard bench for da2_multi (default build or DA2_DBUF_EN)
module tb_da2_multi;

  localparam int H = 2, G = 4;
`ifdef DA2_DBUF_EN
  localparam int GAP_EXP = G;
`else
  localparam int GAP_EXP = G + 1;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        sclk, sync, busy, done, update;
  logic [1:0]  sdata;
  logic [23:0] value;
  logic [3:0]  mode;
  logic [1:0]  ch_en;

  logic        sclk8, sync8, busy8, done8, update8;
  logic [0:0]  sdata8;
  logic [7:0]  value8;
  logic [1:0]  mode8;
  logic [0:0]  en8;

  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp8_q[$];
  bit gap_chk = 0;

  da2_multi #(.NUM_CH(2), .DATA_W(12), .SCLK_HALF(H), .SYNC_GAP(G)) dut (
    .clk(clk), .rst(rst), .SCLK(sclk), .SYNC(sync), .SDATA(sdata),
    .value(value), .mode(mode), .ch_en(ch_en), .update(update),
    .busy(busy), .done(done));

  da2_multi #(.NUM_CH(1), .DATA_W(8), .SCLK_HALF(1), .SYNC_GAP(1)) dut8 (
    .clk(clk), .rst(rst), .SCLK(sclk8), .SYNC(sync8), .SDATA(sdata8),
    .value(value8), .mode(mode8), .ch_en(en8), .update(update8),
    .busy(busy8), .done(done8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: reassembles frames as the DAC would (bits taken at SCLK falls while SYNC low).
  logic [15:0] cap0, cap1, cap8;
  int nbits = 0, low_cnt = 0, high_cnt = 0, nbits8 = 0, low8 = 0;
  logic psclk = 1'b1, psync = 1'b1, psclk8 = 1'b1, psync8 = 1'b1;
  logic [31:0] ef;

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0; low_cnt = 0; high_cnt = 0; psclk = 1'b1; psync = 1'b1;
    end else begin
      if (!sync && psync) begin
        if (gap_chk) chk("sync_gap", high_cnt, GAP_EXP);
        nbits = 0; low_cnt = 0;
      end
      if (!sync) begin
        low_cnt++;
        if (psclk && !sclk) begin
          cap0 = {cap0[14:0], sdata[0]};
          cap1 = {cap1[14:0], sdata[1]};
          nbits++;
        end
      end else high_cnt++;
      if (sync && !psync) begin
        high_cnt = 1;
        chk("frame_bits", nbits, 16);
        chk("sync_low_len", low_cnt, 32 * H);
        if (exp_q.size() == 0) chk("unexpected_frame", {cap1, cap0}, 32'hx);
        else begin
          ef = exp_q.pop_front();
          chk("frame_ch0", cap0, ef[15:0]);
          chk("frame_ch1", cap1, ef[31:16]);
        end
      end
      psclk = sclk; psync = sync;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      nbits8 = 0; low8 = 0; psclk8 = 1'b1; psync8 = 1'b1;
    end else begin
      if (!sync8 && psync8) begin nbits8 = 0; low8 = 0; end
      if (!sync8) begin
        low8++;
        if (psclk8 && !sclk8) begin cap8 = {cap8[14:0], sdata8[0]}; nbits8++; end
      end
      if (sync8 && !psync8) begin
        chk("w8_bits", nbits8, 16);
        chk("w8_sync_low_len", low8, 32);
        if (exp8_q.size() == 0) chk("w8_unexpected_frame", cap8, 32'hx);
        else chk("w8_frame", cap8, exp8_q.pop_front());
      end
      psclk8 = sclk8; psync8 = sync8;
    end
  end

  task automatic pulse(input logic [23:0] v, input logic [3:0] m, input logic [1:0] e,
                       input logic [31:0] expf, input bit push);
    value = v; mode = m; ch_en = e; update = 1'b1;
    if (push) exp_q.push_back(expf);
    @(posedge clk); #1;
    update = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_done(input bit w8, input int bound, output int cyc);
    int got;
    got = 0; cyc = 0;
    while (got < 1 && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
      if (w8 ? done8 : done) got++;
    end
    chk(w8 ? "w8_done_seen" : "done_seen", got, 1);
  endtask

  int cyc, got, falls;
  logic ps;

  initial begin
    update = 0; value = '0; mode = '0; ch_en = '0;
    update8 = 0; value8 = '0; mode8 = '0; en8 = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_sync", sync, 1'b1);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_sdata", sdata, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // both channels loaded
    pulse({12'h3FF, 12'hAAA}, 4'b0000, 2'b11, {16'h03FF, 16'h0AAA}, 1);
    wait_done(0, 200, cyc);
    chk("done_latency", cyc, 32 * H + G);
    chk("busy_after_done", busy, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);

    // ch1 masked: resends its old frame
    pulse({12'h123, 12'h456}, {2'b11, 2'b01}, 2'b01, {16'h03FF, 16'h1456}, 1);
    wait_done(0, 200, cyc);

    // update held high for back-to-back frames
    for (int i = 0; i < 3; i++) exp_q.push_back({16'h2001, 16'h0800});
`ifdef DA2_DBUF_EN
    exp_q.push_back({16'h2001, 16'h0800});
`endif
    value = {12'h001, 12'h800}; mode = {2'b10, 2'b00}; ch_en = 2'b11; update = 1'b1;
    got = 0; cyc = 0;
    while (got < 3 && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin got++; gap_chk = 1; end
    end
    update = 1'b0;
    chk("held_done_count", got, 3);
`ifdef DA2_DBUF_EN
    wait_done(0, 200, cyc);
`endif
    gap_chk = 0;
    repeat (3) @(posedge clk); #1;

    // reset mid-frame after the 8th fall
    pulse({12'h555, 12'h777}, 4'b0000, 2'b11, 32'h0, 0);
    falls = 0; cyc = 0; ps = sclk;
    while (falls < 8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ps && !sclk) falls++;
      ps = sclk;
    end
    chk("falls_before_abort", falls, 8);
    #1 rst = 1'b1;
    #1;
    chk("abort_sync", sync, 1'b1);
    chk("abort_sclk", sclk, 1'b1);
    chk("abort_sdata", sdata, 2'b00);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    pulse({12'hFFF, 12'h0F0}, {2'b01, 2'b00}, 2'b01, {16'h0000, 16'h00F0}, 1);
    wait_done(0, 200, cyc);

    // update while busy
    pulse({12'h0AB, 12'h0CD}, 4'b0000, 2'b11, {16'h00AB, 16'h00CD}, 1);
    repeat (20) @(posedge clk);
    #1;
    value = {12'h111, 12'h222}; mode = 4'b0000; ch_en = 2'b11; update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0; value = 24'hFFFFFF; mode = 4'b1111; ch_en = 2'b00;
`ifdef DA2_DBUF_EN
    exp_q.push_back({16'h0111, 16'h0222});
    wait_done(0, 200, cyc);
    chk("busy_kept_for_pending", busy, 1'b1);
    wait_done(0, 200, cyc);
    pulse(24'hFFFFFF, 4'b1111, 2'b00, {16'h0111, 16'h0222}, 1);
`else
    wait_done(0, 200, cyc);
    chk("busy_low_no_pending", busy, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    pulse(24'hFFFFFF, 4'b1111, 2'b00, {16'h00AB, 16'h00CD}, 1);
`endif
    wait_done(0, 200, cyc);

    // 8-bit sample width, left-justified
    value8 = 8'hC3; mode8 = 2'b00; en8 = 1'b1; update8 = 1'b1;
    exp8_q.push_back(16'h0C30);
    @(posedge clk); #1 update8 = 1'b0;
    wait_done(1, 100, cyc);
    chk("w8_done_latency", cyc, 33);
    value8 = 8'h5A; mode8 = 2'b10; update8 = 1'b1;
    exp8_q.push_back(16'h25A0);
    @(posedge clk); #1 update8 = 1'b0;
    wait_done(1, 100, cyc);

    repeat (50) @(posedge clk);
    #1;
    chk("frames_left", exp_q.size(), 0);
    chk("w8_frames_left", exp8_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
